// File: rtl/inferno_rom_loader_if.sv
// Download bus between the HPS ioctl stream (master side) and the williams2 ROM loader (slave side).
interface inferno_rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] ioctl_index;
  logic [17:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [3:0]  dn_region;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  dn_addr, dn_data, dn_wr, dn_region
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output dn_addr, dn_data, dn_wr, dn_region
  );
endinterface

// File: rtl/inferno_rom_loader.sv
// ROM download front-end: registers/decodes ioctl bytes, checks length and range, holds core reset.
// Optional per-region byte sums enabled by defining LOADER_CHECKSUM_EN.
module inferno_rom_loader #(
  parameter logic [17:0] EXPECTED_LEN = 18'h30400,
  parameter int          HOLD_CYCLES  = 16,
  parameter int          PROM_SIZE    = 1024
`ifdef LOADER_CHECKSUM_EN
  ,
  parameter logic [31:0] EXPECTED_SUM = 32'h0
`endif
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  inferno_rom_loader_if.slave        bus,
  output logic                       core_reset,
  output logic                       load_done,
  output logic                       load_err,
  output logic [17:0]                byte_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]                region_sum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_t;

  localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES - 1);
  localparam logic [16:0] PROM_LIM  = 17'(PROM_SIZE);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_enter_load;
  logic        w_core_reset;

  logic [7:0]  r_hold;
  logic [17:0] r_byte_count;
  logic        r_range_err;
  logic        r_load_done;
  logic        r_load_err;
  logic [17:0] r_dn_addr;
  logic [7:0]  r_dn_data;
  logic        r_dn_wr;
  logic [3:0]  r_dn_region;

  logic        w_idx0;
  logic        w_start;
  logic        w_accept;
  logic [1:0]  w_region;
  logic        w_oob;
  logic        w_write;
  logic        w_hold_done;
  logic        w_sum_err;
  logic        w_final_err;

  assign w_idx0      = (bus.ioctl_index == 16'd0);
  assign w_start     = bus.ioctl_download && w_idx0;
  assign w_accept    = (r_state == S_LOAD) && bus.ioctl_wr && w_idx0;
  assign w_region    = bus.ioctl_addr[17:16];
  assign w_oob       = (|bus.ioctl_addr[24:18]) ||
                       ((w_region == 2'd3) && ({1'b0, bus.ioctl_addr[15:0]} >= PROM_LIM));
  assign w_write     = w_accept && !w_oob;
  assign w_hold_done = (r_state == S_HOLD) && (r_hold == 8'd0);
  assign w_final_err = r_range_err || (r_byte_count != EXPECTED_LEN) || w_sum_err;

`ifdef LOADER_CHECKSUM_EN
  logic [3:0][7:0] r_sum;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sum <= '0;
    end else if (w_enter_load) begin
      r_sum <= '0;
    end else if (w_write) begin
      r_sum[w_region] <= r_sum[w_region] + bus.ioctl_dout;
    end
  end

  // A zero expected sum means "no reference available", so skip the compare.
  assign w_sum_err  = (EXPECTED_SUM != 32'h0) && (r_sum != EXPECTED_SUM);
  assign region_sum = r_sum;
`else
  assign w_sum_err  = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_enter_load = 1'b0;
    w_core_reset = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt  = S_LOAD;
          w_enter_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (!bus.ioctl_download) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold == 8'd0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_core_reset = 1'b0;
        if (w_start) begin
          w_state_nxt  = S_LOAD;
          w_enter_load = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hold       <= 8'd0;
      r_byte_count <= 18'd0;
      r_range_err  <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_dn_addr    <= 18'd0;
      r_dn_data    <= 8'd0;
      r_dn_wr      <= 1'b0;
      r_dn_region  <= 4'd0;
    end else begin
      r_dn_wr <= w_write;
      if (w_accept) begin
        r_dn_addr   <= bus.ioctl_addr[17:0];
        r_dn_data   <= bus.ioctl_dout;
        r_dn_region <= 4'b0001 << w_region;
      end

      if ((r_state == S_LOAD) && !bus.ioctl_download) r_hold <= HOLD_INIT;
      else if ((r_state == S_HOLD) && (r_hold != 8'd0)) r_hold <= r_hold - 8'd1;

      if (w_enter_load) begin
        r_byte_count <= 18'd0;
        r_range_err  <= 1'b0;
        r_load_done  <= 1'b0;
        r_load_err   <= 1'b0;
      end else begin
        if (w_accept && (r_byte_count != 18'h3FFFF)) r_byte_count <= r_byte_count + 18'd1;
        // Range errors are latched here and published with the verdict, so flags stay put mid-load.
        if (w_accept && w_oob) r_range_err <= 1'b1;
        if (w_hold_done) begin
          r_load_err  <= w_final_err;
          r_load_done <= ~w_final_err;
        end
      end
    end
  end

  assign bus.dn_addr   = r_dn_addr;
  assign bus.dn_data   = r_dn_data;
  assign bus.dn_wr     = r_dn_wr;
  assign bus.dn_region = r_dn_region;
  assign core_reset    = w_core_reset;
  assign load_done     = r_load_done;
  assign load_err      = r_load_err;
  assign byte_count    = r_byte_count;

endmodule
